// File: rtl/risc_cpu_pkg.sv
// Shared definitions for the risc_cpu core: opcodes, instruction field positions,
// memory depths, the ALU operation set and the boot program image.
package risc_cpu_pkg;

    localparam int IMEM_DEPTH_DEF = 64;
    localparam int DMEM_DEPTH_DEF = 64;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 21;
    localparam int RS_MSB  = 20;
    localparam int RS_LSB  = 16;
    localparam int RT_MSB  = 15;
    localparam int RT_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_AND  = 6'd3;
    localparam logic [5:0] OP_OR   = 6'd4;
    localparam logic [5:0] OP_XOR  = 6'd5;
    localparam logic [5:0] OP_SLT  = 6'd6;
    localparam logic [5:0] OP_ADDI = 6'd7;
    localparam logic [5:0] OP_LW   = 6'd8;
    localparam logic [5:0] OP_SW   = 6'd9;
    localparam logic [5:0] OP_BEQ  = 6'd10;
    localparam logic [5:0] OP_BNE  = 6'd11;
    localparam logic [5:0] OP_JMP  = 6'd12;
    localparam logic [5:0] OP_HALT = 6'd63;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_op_e;

    // Register-form encoder; the rt field overlaps imm[15:11].
    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
        return {op, rd, rs, rt, 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [IMEM_DEPTH_DEF-1:0][31:0] boot_rom();
        logic [IMEM_DEPTH_DEF-1:0][31:0] rom;
        rom     = '0;
        rom[0]  = enc_i(OP_ADDI, 5'd1, 5'd0, 16'd10);
        rom[1]  = enc_i(OP_ADDI, 5'd2, 5'd0, 16'd3);
        rom[2]  = enc_r(OP_ADD,  5'd3, 5'd1, 5'd2);
        rom[3]  = enc_r(OP_SUB,  5'd4, 5'd1, 5'd2);
        rom[4]  = enc_r(OP_AND,  5'd5, 5'd1, 5'd2);
        rom[5]  = enc_r(OP_OR,   5'd6, 5'd1, 5'd2);
        rom[6]  = enc_i(OP_SW,   5'd3, 5'd0, 16'd0);
        rom[7]  = enc_i(OP_LW,   5'd7, 5'd0, 16'd0);
        rom[8]  = enc_i(OP_ADDI, 5'd8, 5'd8, 16'd1);
        rom[9]  = enc_i(OP_BNE,  5'd8, 5'd1, 16'hFFFE);
        rom[10] = enc_r(OP_HALT, 5'd0, 5'd0, 5'd0);
        return rom;
    endfunction

    localparam logic [IMEM_DEPTH_DEF-1:0][31:0] BOOT_ROM = boot_rom();

endpackage

// File: rtl/risc_cpu_if.sv
// Operand/result bundle between the core's decode logic and its ALU.
interface risc_cpu_if;
    import risc_cpu_pkg::*;

    logic [31:0] a;
    logic [31:0] b;
    alu_op_e     op;
    logic [31:0] y;

    modport master (output a, b, op, input y);
    modport slave  (input a, b, op, output y);
endinterface

// File: rtl/risc_cpu_alu.sv
// Combinational 32-bit ALU; wraps modulo 2^32 and raises no flags.
module risc_alu
    import risc_cpu_pkg::*;
(
    risc_cpu_if.slave alu
);
    always_comb begin
        alu.y = 32'd0;
        case (alu.op)
            ALU_ADD: alu.y = alu.a + alu.b;
            ALU_SUB: alu.y = alu.a - alu.b;
            ALU_AND: alu.y = alu.a & alu.b;
            ALU_OR:  alu.y = alu.a | alu.b;
            ALU_XOR: alu.y = alu.a ^ alu.b;
            ALU_SLT: alu.y = {31'd0, ($signed(alu.a) < $signed(alu.b))};
            default: alu.y = 32'd0;
        endcase
    end
endmodule

// File: rtl/risc_cpu.sv
// Single-cycle RISC core: fetch, decode, execute and commit all happen on one edge.
// Register file, pc, halt flag and data RAM are observable hierarchically only.
module risc_cpu
    import risc_cpu_pkg::*;
#(
    parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter int DMEM_DEPTH = DMEM_DEPTH_DEF,
    parameter logic [IMEM_DEPTH-1:0][31:0] ROM_IMAGE = BOOT_ROM
) (
    input logic clk,
    input logic reset
);
    logic [31:0] R [32];
    logic [5:0]  pc;
    logic        halted;
    logic [31:0] dmem [DMEM_DEPTH];

    logic [31:0] w_instr;
    logic [5:0]  w_op;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [31:0] w_imm;
    logic [31:0] w_rd_val;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    alu_op_e     w_alu_op;
    logic        w_use_imm;
    logic        w_reg_we;
    logic        w_wb_mem;
    logic        w_mem_we;
    logic        w_halt;
    logic [5:0]  w_pc_inc;
    logic [5:0]  w_pc_next;
    logic [5:0]  w_mem_addr;
    logic [31:0] w_mem_rdata;
    logic [31:0] w_wdata;

    risc_cpu_if w_alu_if ();
    risc_alu u_alu (.alu(w_alu_if.slave));

    // Words beyond the ROM image read as zero, which decodes as NOP.
    assign w_instr = (32'(pc) < 32'(IMEM_DEPTH)) ? ROM_IMAGE[pc] : 32'd0;

    assign w_op  = w_instr[OP_MSB:OP_LSB];
    assign w_rd  = w_instr[RD_MSB:RD_LSB];
    assign w_rs  = w_instr[RS_MSB:RS_LSB];
    assign w_rt  = w_instr[RT_MSB:RT_LSB];
    assign w_imm = {{16{w_instr[IMM_MSB]}}, w_instr[IMM_MSB:IMM_LSB]};

    assign w_rd_val = (w_rd == 5'd0) ? 32'd0 : R[w_rd];
    assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : R[w_rs];
    assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : R[w_rt];

    assign w_alu_if.a  = w_rs_val;
    assign w_alu_if.b  = w_use_imm ? w_imm : w_rt_val;
    assign w_alu_if.op = w_alu_op;

    assign w_mem_addr  = w_alu_if.y[5:0];
    assign w_mem_rdata = (32'(w_mem_addr) < 32'(DMEM_DEPTH)) ? dmem[w_mem_addr] : 32'd0;
    assign w_wdata     = w_wb_mem ? w_mem_rdata : w_alu_if.y;
    assign w_pc_inc    = pc + 6'd1;

    always_comb begin
        w_alu_op  = ALU_ADD;
        w_use_imm = 1'b0;
        w_reg_we  = 1'b0;
        w_wb_mem  = 1'b0;
        w_mem_we  = 1'b0;
        w_halt    = 1'b0;
        w_pc_next = w_pc_inc;
        case (w_op)
            OP_ADD:  begin w_alu_op = ALU_ADD; w_reg_we = 1'b1; end
            OP_SUB:  begin w_alu_op = ALU_SUB; w_reg_we = 1'b1; end
            OP_AND:  begin w_alu_op = ALU_AND; w_reg_we = 1'b1; end
            OP_OR:   begin w_alu_op = ALU_OR;  w_reg_we = 1'b1; end
            OP_XOR:  begin w_alu_op = ALU_XOR; w_reg_we = 1'b1; end
            OP_SLT:  begin w_alu_op = ALU_SLT; w_reg_we = 1'b1; end
            OP_ADDI: begin w_use_imm = 1'b1; w_reg_we = 1'b1; end
            OP_LW:   begin w_use_imm = 1'b1; w_reg_we = 1'b1; w_wb_mem = 1'b1; end
            OP_SW:   begin w_use_imm = 1'b1; w_mem_we = 1'b1; end
            OP_BEQ:  if (w_rd_val == w_rs_val) w_pc_next = w_pc_inc + w_imm[5:0];
            OP_BNE:  if (w_rd_val != w_rs_val) w_pc_next = w_pc_inc + w_imm[5:0];
            OP_JMP:  w_pc_next = w_imm[5:0];
            OP_HALT: begin w_halt = 1'b1; w_pc_next = pc; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= 6'd0;
            halted <= 1'b0;
        end else if (!halted) begin
            pc     <= w_pc_next;
            halted <= w_halt;
        end
    end

    // R[0] is never written, so it holds its reset value of zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) R[i] <= 32'd0;
        end else if (!halted && w_reg_we && (w_rd != 5'd0)) begin
            R[w_rd] <= w_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= 32'd0;
        end else if (!halted && w_mem_we && (32'(w_mem_addr) < 32'(DMEM_DEPTH))) begin
            dmem[w_mem_addr] <= w_rd_val;
        end
    end
endmodule

// File: tb/tb_risc_cpu.sv
// Directed bench for risc_cpu: boot program timing, halt, async reset, alternate ROMs
// and a standalone ALU instance driven through the operand interface.
`timescale 1ns/1ps
module tb_risc_cpu;
    import risc_cpu_pkg::*;

    function automatic logic [63:0][31:0] alt_rom();
        logic [63:0][31:0] rom;
        rom    = '0;
        rom[0] = enc_i(OP_ADDI, 5'd0, 5'd0, 16'd5);
        rom[1] = enc_i(OP_ADDI, 5'd9, 5'd0, 16'hFFFF);
        rom[2] = enc_r(OP_ADD,  5'd10, 5'd9, 5'd9);
        rom[3] = enc_r(OP_SLT,  5'd11, 5'd9, 5'd0);
        rom[4] = enc_r(OP_HALT, 5'd0, 5'd0, 5'd0);
        return rom;
    endfunction

    function automatic logic [63:0][31:0] br_rom();
        logic [63:0][31:0] rom;
        rom     = '0;
        rom[0]  = enc_i(OP_ADDI, 5'd1, 5'd0, 16'd7);
        rom[1]  = enc_i(OP_ADDI, 5'd4, 5'd0, 16'd12);
        rom[2]  = enc_i(OP_BEQ,  5'd1, 5'd0, 16'd5);
        rom[3]  = enc_i(OP_BEQ,  5'd1, 5'd1, 16'd1);
        rom[4]  = enc_i(OP_ADDI, 5'd2, 5'd0, 16'd99);
        rom[5]  = enc_r(OP_XOR,  5'd3, 5'd1, 5'd4);
        rom[6]  = enc_i(OP_SW,   5'd3, 5'd0, 16'd67);
        rom[7]  = enc_i(OP_LW,   5'd5, 5'd0, 16'd3);
        rom[8]  = enc_i(6'd13,   5'd6, 5'd1, 16'd1);
        rom[9]  = enc_i(OP_JMP,  5'd0, 5'd0, 16'd12);
        rom[10] = enc_i(OP_ADDI, 5'd2, 5'd0, 16'd55);
        rom[11] = enc_r(OP_HALT, 5'd0, 5'd0, 5'd0);
        rom[12] = enc_i(OP_ADDI, 5'd7, 5'd0, 16'hFFFB);
        rom[13] = enc_r(OP_SLT,  5'd8, 5'd7, 5'd1);
        rom[14] = enc_r(OP_ADD,  5'd1, 5'd1, 5'd1);
        rom[15] = enc_r(OP_HALT, 5'd0, 5'd0, 5'd0);
        return rom;
    endfunction

    localparam logic [63:0][31:0] ALT_ROM = alt_rom();
    localparam logic [63:0][31:0] BR_ROM  = br_rom();

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] exp_r [32];

    // Clock / reset: 10 ns period, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    risc_cpu dut (.clk(clk), .reset(reset));
    risc_cpu #(.IMEM_DEPTH(64), .DMEM_DEPTH(64), .ROM_IMAGE(ALT_ROM)) dut_alt (.clk(clk), .reset(reset));
    risc_cpu #(.IMEM_DEPTH(64), .DMEM_DEPTH(64), .ROM_IMAGE(BR_ROM))  dut_br  (.clk(clk), .reset(reset));

    risc_cpu_if alu_if ();
    risc_alu u_alu (.alu(alu_if.slave));

    task automatic wait_until(input longint t);
        if ($time < t) #(t - $time);
    endtask

    task automatic set_boot_expect(input logic [31:0] r8);
        for (int i = 0; i < 32; i++) exp_r[i] = 32'd0;
        exp_r[1] = 32'd10; exp_r[2] = 32'd3;  exp_r[3] = 32'd13; exp_r[4] = 32'd7;
        exp_r[5] = 32'd2;  exp_r[6] = 32'd11; exp_r[7] = 32'd13; exp_r[8] = r8;
    endtask

    task automatic test_alu();
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic [31:0] vy [8];
        alu_op_e     vo [8];
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0000_0001; vo[0] = ALU_ADD; vy[0] = 32'h0000_0000;
        va[1] = 32'h0000_0000; vb[1] = 32'h0000_0001; vo[1] = ALU_SUB; vy[1] = 32'hFFFF_FFFF;
        va[2] = 32'hF0F0_1234; vb[2] = 32'hFF00_00FF; vo[2] = ALU_AND; vy[2] = 32'hF000_0034;
        va[3] = 32'hF0F0_1234; vb[3] = 32'hFF00_00FF; vo[3] = ALU_OR;  vy[3] = 32'hFFF0_12FF;
        va[4] = 32'hF0F0_1234; vb[4] = 32'hFF00_00FF; vo[4] = ALU_XOR; vy[4] = 32'h0FF0_12CB;
        va[5] = 32'hFFFF_FFFF; vb[5] = 32'h0000_0000; vo[5] = ALU_SLT; vy[5] = 32'h0000_0001;
        va[6] = 32'h0000_0005; vb[6] = 32'hFFFF_FFFD; vo[6] = ALU_SLT; vy[6] = 32'h0000_0000;
        va[7] = 32'h0000_0007; vb[7] = 32'h0000_0007; vo[7] = ALU_SLT; vy[7] = 32'h0000_0000;
        for (int i = 0; i < 8; i++) begin
            alu_if.a  = va[i];
            alu_if.b  = vb[i];
            alu_if.op = vo[i];
            #1;
            n_cmp++;
            if (alu_if.y !== vy[i]) begin
                n_bad++;
                $display("FAIL alu_vec%0d: got %h expected %h", i, alu_if.y, vy[i]);
            end
        end
    endtask

    task automatic test_reset();
        wait_until(19);
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (dut.R[i] !== 32'd0) begin
                n_bad++;
                $display("FAIL reset_R%0d: got %h expected 0", i, dut.R[i]);
            end
        end
        n_cmp++;
        if (dut.pc !== 6'd0) begin n_bad++; $display("FAIL reset_pc: got %0d expected 0", dut.pc); end
        n_cmp++;
        if (dut.halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b expected 0", dut.halted); end
        n_cmp++;
        if (dut.dmem[0] !== 32'd0) begin n_bad++; $display("FAIL reset_dmem0: got %h expected 0", dut.dmem[0]); end
        wait_until(20);
        reset = 1'b0;
    endtask

    // Twenty edges after release: the loop has run six times and just took the BNE.
    task automatic test_boot_program(input longint t_sample);
        set_boot_expect(32'd6);
        wait_until(t_sample);
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (dut.R[i] !== exp_r[i]) begin
                n_bad++;
                $display("FAIL boot_R%0d@%0d: got %h expected %h", i, t_sample, dut.R[i], exp_r[i]);
            end
        end
        n_cmp++;
        if (dut.pc !== 6'd8) begin n_bad++; $display("FAIL boot_pc@%0d: got %0d expected 8", t_sample, dut.pc); end
        n_cmp++;
        if (dut.halted !== 1'b0) begin n_bad++; $display("FAIL boot_halted@%0d: got %b expected 0", t_sample, dut.halted); end
        n_cmp++;
        if (dut.dmem[0] !== 32'd13) begin n_bad++; $display("FAIL boot_dmem0@%0d: got %h expected 0000000d", t_sample, dut.dmem[0]); end
    endtask

    task automatic test_async_reset();
        wait_until(233);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (dut.R[i] !== 32'd0) begin
                n_bad++;
                $display("FAIL async_R%0d: got %h expected 0", i, dut.R[i]);
            end
        end
        n_cmp++;
        if (dut.pc !== 6'd0) begin n_bad++; $display("FAIL async_pc: got %0d expected 0", dut.pc); end
        n_cmp++;
        if (dut.dmem[0] !== 32'd0) begin n_bad++; $display("FAIL async_dmem0: got %h expected 0", dut.dmem[0]); end
        wait_until(240);
        reset = 1'b0;
    endtask

    task automatic test_halt(input longint t1, input longint t2);
        logic [31:0] snap [32];
        set_boot_expect(32'd10);
        wait_until(t1);
        for (int i = 0; i < 32; i++) begin
            snap[i] = dut.R[i];
            n_cmp++;
            if (dut.R[i] !== exp_r[i]) begin
                n_bad++;
                $display("FAIL halt1_R%0d: got %h expected %h", i, dut.R[i], exp_r[i]);
            end
        end
        n_cmp++;
        if (dut.halted !== 1'b1) begin n_bad++; $display("FAIL halt1_halted: got %b expected 1", dut.halted); end
        n_cmp++;
        if (dut.pc !== 6'd10) begin n_bad++; $display("FAIL halt1_pc: got %0d expected 10", dut.pc); end
        wait_until(t2);
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (dut.R[i] !== exp_r[i] || dut.R[i] !== snap[i]) begin
                n_bad++;
                $display("FAIL halt2_R%0d: got %h expected %h (earlier dump %h)", i, dut.R[i], exp_r[i], snap[i]);
            end
        end
        n_cmp++;
        if (dut.halted !== 1'b1) begin n_bad++; $display("FAIL halt2_halted: got %b expected 1", dut.halted); end
        n_cmp++;
        if (dut.pc !== 6'd10) begin n_bad++; $display("FAIL halt2_pc: got %0d expected 10", dut.pc); end
        n_cmp++;
        if (dut.dmem[0] !== 32'd13) begin n_bad++; $display("FAIL halt2_dmem0: got %h expected 0000000d", dut.dmem[0]); end
    endtask

    task automatic test_alt_rom();
        for (int i = 0; i < 32; i++) exp_r[i] = 32'd0;
        exp_r[9] = 32'hFFFF_FFFF; exp_r[10] = 32'hFFFF_FFFE; exp_r[11] = 32'd1;
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (dut_alt.R[i] !== exp_r[i]) begin
                n_bad++;
                $display("FAIL alt_R%0d: got %h expected %h", i, dut_alt.R[i], exp_r[i]);
            end
        end
        n_cmp++;
        if (dut_alt.halted !== 1'b1) begin n_bad++; $display("FAIL alt_halted: got %b expected 1", dut_alt.halted); end
        n_cmp++;
        if (dut_alt.pc !== 6'd4) begin n_bad++; $display("FAIL alt_pc: got %0d expected 4", dut_alt.pc); end
    endtask

    task automatic test_branch_jump();
        for (int i = 0; i < 32; i++) exp_r[i] = 32'd0;
        exp_r[1] = 32'd14; exp_r[3] = 32'd11; exp_r[4] = 32'd12; exp_r[5] = 32'd11;
        exp_r[7] = 32'hFFFF_FFFB; exp_r[8] = 32'd1;
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (dut_br.R[i] !== exp_r[i]) begin
                n_bad++;
                $display("FAIL br_R%0d: got %h expected %h", i, dut_br.R[i], exp_r[i]);
            end
        end
        n_cmp++;
        if (dut_br.dmem[3] !== 32'd11) begin n_bad++; $display("FAIL br_dmem3: got %h expected 0000000b", dut_br.dmem[3]); end
        n_cmp++;
        if (dut_br.pc !== 6'd15) begin n_bad++; $display("FAIL br_pc: got %0d expected 15", dut_br.pc); end
        n_cmp++;
        if (dut_br.halted !== 1'b1) begin n_bad++; $display("FAIL br_halted: got %b expected 1", dut_br.halted); end
    endtask

    initial begin
        reset = 1'b1;
        test_alu();
        test_reset();
        test_boot_program(220);
        test_async_reset();
        test_boot_program(440);
        test_halt(640, 1040);
        test_alt_rom();
        test_branch_jump();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
